// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
//   Turns one 128-bit vector load/store into LANES sequential DATA_W-bit
//   accesses on a single-port RAM, stalling the pipeline meanwhile.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   req_valid/write/base/wdata  vector request (level, held until done)
//   stall, busy, done  pipeline hold, non-idle flag, completion pulse
//   mem_addr/wdata/wren/q       RAM data port
//   rdata             packed load result, lane i = bits[DATA_W*i +: DATA_W]
module vector_mem_sequencer #(
  parameter int LANES    = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_base,
  input  logic [LANES*DATA_W-1:0]   req_wdata,
  output logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q,
  output logic [LANES*DATA_W-1:0]   rdata
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                    state;
  logic                      wr_r;
  logic [ADDR_W-1:0]         base_r;
  logic [LANES*DATA_W-1:0]   wdata_r;
  logic [IW-1:0]             idx;
  logic [CW-1:0]             drain_cnt;
  // Capture pipeline: lane index and valid follow idx by READ_LAT cycles so
  // mem_q lands in the lane whose address was issued READ_LAT cycles ago.
  logic [READ_LAT-1:0]          vld_pipe;
  logic [READ_LAT-1:0][IW-1:0]  cap_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_r      <= 1'b0;
      base_r    <= '0;
      wdata_r   <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      cap_idx   <= '0;
      rdata     <= '0;
    end else begin
      vld_pipe[0] <= (state == ISSUE) && !wr_r;
      cap_idx[0]  <= idx;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        cap_idx[i]  <= cap_idx[i-1];
      end
      if (vld_pipe[READ_LAT-1])
        rdata[cap_idx[READ_LAT-1]*DATA_W +: DATA_W] <= mem_q;

      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_r    <= req_write;
            base_r  <= req_base;
            wdata_r <= req_wdata;
            idx     <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx == IW'(LANES - 1)) begin
            idx       <= '0;
            drain_cnt <= '0;
            state     <= wr_r ? DONE : DRAIN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DRAIN: begin
          // Last lane's data arrives READ_LAT cycles after its address.
          if (drain_cnt == CW'(READ_LAT - 1)) state <= DONE;
          else drain_cnt <= drain_cnt + CW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign stall     = ((state == IDLE) && req_valid) || (state == ISSUE) || (state == DRAIN);
  assign mem_wren  = (state == ISSUE) && wr_r;
  // Address adder is ADDR_W wide, so base+idx wraps naturally.
  assign mem_addr  = (state == ISSUE) ? base_r + ADDR_W'(idx) : '0;
  assign mem_wdata = mem_wren ? wdata_r[idx*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: u0 built with READ_LAT=1, u1 with
// READ_LAT=2, each with its own RAM model.
module tb_vector_mem_sequencer;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid0, req_valid1, req_write;
  logic [15:0]  req_base;
  logic [127:0] req_wdata;

  logic         stall0, busy0, done0, wren0, stall1, busy1, done1, wren1;
  logic [15:0]  addr0, wdata0, q0, addr1, wdata1, q1;
  logic [127:0] rdata0, rdata1;

  logic [15:0]  ram0 [0:65535];
  logic [15:0]  ram1 [0:65535];
  logic [15:0]  r1a, r1b;

  int n_cmp = 0;
  int n_bad = 0;

  // per-request trace
  int           done_cyc, n_wr;
  logic [31:0]  stall_tr, busy_tr;
  logic [15:0]  log_addr [8];
  logic [15:0]  log_wdata [8];
  logic         log_wren [8];
  logic [127:0] rd;

  always #5 clk = ~clk;

  vector_mem_sequencer #(.LANES(8), .DATA_W(16), .ADDR_W(16), .READ_LAT(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write),
    .req_base(req_base), .req_wdata(req_wdata), .stall(stall0), .busy(busy0),
    .done(done0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_wren(wren0),
    .mem_q(q0), .rdata(rdata0));

  vector_mem_sequencer #(.LANES(8), .DATA_W(16), .ADDR_W(16), .READ_LAT(2)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_write(req_write),
    .req_base(req_base), .req_wdata(req_wdata), .stall(stall1), .busy(busy1),
    .done(done1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_wren(wren1),
    .mem_q(q1), .rdata(rdata1));

  always @(posedge clk) begin
    if (wren0) ram0[addr0] <= wdata0;
    q0 <= ram0[addr0];
  end

  always @(posedge clk) begin
    if (wren1) ram1[addr1] <= wdata1;
    r1a <= ram1[addr1];
    r1b <= r1a;
  end
  assign q1 = r1b;

  // Present one request on unit sel and trace it until done (bounded).
  // Returns at posedge+1 after the done cycle with req_valid dropped.
  task automatic run(input bit sel, input bit wr, input logic [15:0] base,
                     input logic [127:0] wd);
    req_write = wr; req_base = base; req_wdata = wd;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    done_cyc = -1; n_wr = 0; stall_tr = '0; busy_tr = '0; rd = '0;
    for (int c = 0; c < 30 && done_cyc < 0; c++) begin
      @(negedge clk);
      stall_tr[c] = sel ? stall1 : stall0;
      busy_tr[c]  = sel ? busy1 : busy0;
      if (sel ? wren1 : wren0) n_wr++;
      if (c >= 1 && c <= 8) begin
        log_addr[c-1]  = sel ? addr1 : addr0;
        log_wdata[c-1] = sel ? wdata1 : wdata0;
        log_wren[c-1]  = sel ? wren1 : wren0;
      end
      if (sel ? done1 : done0) begin
        done_cyc = c;
        rd = sel ? rdata1 : rdata0;
      end
      @(posedge clk); #1;
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_write = 1'b0; req_base = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({stall0, busy0, done0, wren0} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 0000", {stall0, busy0, done0, wren0});
    end
    n_cmp++;
    if ({addr0, wdata0} !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem got %h want 0", {addr0, wdata0});
    end
    n_cmp++;
    if (rdata0 !== 128'h0) begin
      n_bad++; $display("FAIL reset_rdata got %h want 0", rdata0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    run(1'b0, 1'b1, 16'h0010, 128'h88887777666655554444333322221111);
    n_cmp++;
    if (done_cyc !== 9) begin n_bad++; $display("FAIL store_done_cyc got %0d want 9", done_cyc); end
    n_cmp++;
    if (n_wr !== 8) begin n_bad++; $display("FAIL store_wren_count got %0d want 8", n_wr); end
    n_cmp++;
    if (stall_tr[9:0] !== 10'b0111111111) begin
      n_bad++; $display("FAIL store_stall got %b want 0111111111", stall_tr[9:0]);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_wren[i] !== 1'b1 || log_addr[i] !== 16'h0010 + 16'(i) ||
          log_wdata[i] !== 16'h1111 * 16'(i + 1)) begin
        n_bad++;
        $display("FAIL store_lane%0d got wren=%b addr=%h data=%h want 1 %h %h", i,
                 log_wren[i], log_addr[i], log_wdata[i], 16'h0010 + 16'(i), 16'h1111 * 16'(i + 1));
      end
    end
  endtask

  task automatic test_load;
    run(1'b0, 1'b0, 16'h0010, 128'h0);
    n_cmp++;
    if (done_cyc !== 10) begin n_bad++; $display("FAIL load_done_cyc got %0d want 10", done_cyc); end
    n_cmp++;
    if (n_wr !== 0) begin n_bad++; $display("FAIL load_wren_count got %0d want 0", n_wr); end
    n_cmp++;
    if (rd !== 128'h88887777666655554444333322221111) begin
      n_bad++; $display("FAIL load_rdata got %h want 88887777666655554444333322221111", rd);
    end
    n_cmp++;
    if (stall_tr[10:0] !== 11'b01111111111) begin
      n_bad++; $display("FAIL load_stall got %b want 01111111111", stall_tr[10:0]);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_a [8];
    exp_a = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    run(1'b0, 1'b1, 16'hFFFC, 128'hC008C007C006C005C004C003C002C001);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_addr[i] !== exp_a[i] || log_wren[i] !== 1'b1) begin
        n_bad++; $display("FAIL wrap_store_addr%0d got %h want %h", i, log_addr[i], exp_a[i]);
      end
    end
    run(1'b0, 1'b0, 16'hFFFC, 128'h0);
    n_cmp++;
    if (rd !== 128'hC008C007C006C005C004C003C002C001 || done_cyc !== 10) begin
      n_bad++; $display("FAIL wrap_load got %h at %0d want C008C007C006C005C004C003C002C001 at 10", rd, done_cyc);
    end
    n_cmp++;
    if (log_addr[4] !== 16'h0000 || log_addr[7] !== 16'h0003) begin
      n_bad++; $display("FAIL wrap_load_addr got %h %h want 0000 0003", log_addr[4], log_addr[7]);
    end
  endtask

  task automatic test_back_to_back;
    run(1'b0, 1'b1, 16'h0080, 128'hB008B007B006B005B004B003B002B001);
    n_cmp++;
    if (done_cyc !== 9 || n_wr !== 8) begin
      n_bad++; $display("FAIL b2b_store got done=%0d wr=%0d want 9 8", done_cyc, n_wr);
    end
    // load presented in the cycle right after DONE
    run(1'b0, 1'b0, 16'h0080, 128'h0);
    n_cmp++;
    if (busy_tr[1:0] !== 2'b10 || stall_tr[0] !== 1'b1 || done_cyc !== 10) begin
      n_bad++; $display("FAIL b2b_accept got busy=%b stall0=%b done=%0d want 10 1 10",
                        busy_tr[1:0], stall_tr[0], done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (log_addr[i] !== 16'h0080 + 16'(i) || log_wren[i] !== 1'b0) begin
        n_bad++; $display("FAIL b2b_load_addr%0d got %h want %h", i, log_addr[i], 16'h0080 + 16'(i));
      end
    end
    n_cmp++;
    if (rd !== 128'hB008B007B006B005B004B003B002B001 || n_wr !== 0) begin
      n_bad++; $display("FAIL b2b_rdata got %h wr=%0d want B008B007B006B005B004B003B002B001 0", rd, n_wr);
    end
  endtask

  task automatic test_reset_mid;
    run(1'b0, 1'b1, 16'h0040, {8{16'hDEAD}});
    // store, reset sampled on the edge that ends lane 2
    req_write = 1'b1; req_base = 16'h0040;
    req_wdata = 128'hA007A006A005A004A003A002A001A000;
    req_valid0 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if (addr0 !== 16'h0042 || wren0 !== 1'b1) begin
      n_bad++; $display("FAIL mid_lane2 got addr=%h wren=%b want 0042 1", addr0, wren0);
    end
    reset = 1'b0; req_valid0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({stall0, busy0, done0, wren0, addr0, wdata0} !== 36'h0) begin
      n_bad++; $display("FAIL mid_outputs got %h want 0", {stall0, busy0, done0, wren0, addr0, wdata0});
    end
    n_cmp++;
    if (rdata0 !== 128'h0) begin n_bad++; $display("FAIL mid_rdata got %h want 0", rdata0); end
    reset = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 1'b0, 16'h0040, 128'h0);
    n_cmp++;
    if (rd !== 128'hDEADDEADDEADDEADDEADA002A001A000 || done_cyc !== 10) begin
      n_bad++; $display("FAIL mid_after got %h at %0d want DEADDEADDEADDEADDEADA002A001A000 at 10", rd, done_cyc);
    end
  endtask

  task automatic test_read_lat2;
    run(1'b1, 1'b1, 16'h0020, 128'h5A075A065A055A045A035A025A015A00);
    n_cmp++;
    if (done_cyc !== 9 || n_wr !== 8) begin
      n_bad++; $display("FAIL rl2_store got done=%0d wr=%0d want 9 8", done_cyc, n_wr);
    end
    run(1'b1, 1'b0, 16'h0020, 128'h0);
    n_cmp++;
    if (done_cyc !== 11) begin n_bad++; $display("FAIL rl2_done_cyc got %0d want 11", done_cyc); end
    n_cmp++;
    if (rd !== 128'h5A075A065A055A045A035A025A015A00) begin
      n_bad++; $display("FAIL rl2_rdata got %h want 5A075A065A055A045A035A025A015A00", rd);
    end
    n_cmp++;
    if (stall_tr[11:0] !== 12'b011111111111) begin
      n_bad++; $display("FAIL rl2_stall got %b want 011111111111", stall_tr[11:0]);
    end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    test_read_lat2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Sequences one 128-bit vector load or store as eight 16-bit accesses on a single RAM data port.
- Sits between the Execute/Memory stage and the RAM, in place of the direct 128-bit vector port.
- Holds the pipeline through the stall output until every lane has been transferred.
- On a load, delivers the packed 128-bit result for vector writeback.

Parameters:
- LANES, 8, number of 16-bit lanes per vector.
- DATA_W, 16, lane width in bits; the vector width is LANES*DATA_W.
- ADDR_W, 16, RAM word-address width.
- READ_LAT, 1, RAM read latency in cycles from the address edge to q valid; must be ≥1.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-low; 0 on a rising edge resets the block.
- req_valid  input  1  vector memory request; level signal, held until done is seen.
- req_write  input  1  1 = store, 0 = load; sampled at accept.
- req_base  input  ADDR_W  base word address; sampled at accept.
- req_wdata  input  LANES*DATA_W  store data, lane i = bits[16i+15:16i]; sampled at accept.
- stall  output  1  freeze the pipeline stages up to Execute.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse: transfer complete; rdata is valid for loads.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_wren  output  1  RAM write enable.
- mem_q  input  DATA_W  RAM read data.
- rdata  output  LANES*DATA_W  packed load result.

Behaviour:
- States and transitions:
  - IDLE → (req_valid) ISSUE.
  - ISSUE → (LANES accesses issued) DRAIN if load, DONE if store.
  - DRAIN → (READ_LAT cycles elapsed) DONE.
  - DONE → IDLE, unconditionally.
- Accept: in IDLE with req_valid=1, latch req_write, req_base and req_wdata; clear lane counter idx.
- Requests are accepted only in IDLE. req_valid in any other state is ignored.
- ISSUE, one lane per cycle, idx = 0..LANES-1:
  - mem_addr = base + idx, modulo 2^ADDR_W; wrap-around is required (base 0xFFFE gives 0xFFFE, 0xFFFF, 0x0000, …).
  - Store: mem_wren=1, mem_wdata = latched lane idx.
  - Load: mem_wren=0.
  - idx increments each cycle.
- Load capture: mem_q is sampled READ_LAT cycles after lane k's address cycle and written into rdata lane k, via a capture counter delayed READ_LAT from idx. Capture continues through DRAIN.
- rdata is updated lane by lane during a load. It holds its value across stores and IDLE until the next load overwrites it.
- stall = (IDLE & req_valid) | ISSUE | DRAIN. stall=0 in DONE, so the pipeline advances at the end of DONE and drops or replaces req_valid.
- Outputs: done=1 only in DONE. mem_wren=1 only in ISSUE during a store.
- Outside ISSUE: mem_addr=0, mem_wdata=0.
- Latency from the accept edge to done:
  - Store: LANES+1 cycles (accept, 8 write cycles, DONE).
  - Load: LANES+READ_LAT+1 cycles.
- A new request present in the cycle after DONE is accepted normally, with no idle bubble required.
- Reset (reset=0 on a clock edge), including mid-transfer:
  - state=IDLE, idx=0, rdata=0.
  - All outputs 0: stall, busy, done, mem_wren, mem_addr, mem_wdata.
  - Partially written RAM contents are left as-is.

Test Plan:
- Store, base=0x0010, wdata lanes 0..7 = 0x1111..0x8888:
  - mem_wren high for exactly 8 cycles at addresses 0x0010..0x0017 with matching data.
  - done pulses 9 cycles after accept.
  - stall high from the request cycle through the last write.
- Load after that store, base=0x0010, RAM model READ_LAT=1:
  - rdata = 0x8888777766665555444433332222_1111 at the done pulse.
  - done 10 cycles after accept.
  - mem_wren stays 0 throughout.
- Wrap-around store, base=0xFFFC: addresses 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003; a following load returns identical lanes.
- Back-to-back: store held until done, then a load presented the very next cycle.
  - The load is accepted in that cycle.
  - No lost or duplicated lane accesses.
- Reset asserted (0) at lane 3 of a store:
  - Next cycle: state IDLE, all outputs 0, rdata=0.
  - Only lanes 0..2 written.
  - A later request completes normally.
- READ_LAT=2 build: load done at accept+11 cycles; all 8 lanes captured in correct order.
